// File: rtl/ring_buffer_if.sv
// Requester-side handshake bundle for ring_buffer_ctrl: write/read requests,
// acknowledgements, flush and occupancy status.
interface ring_buffer_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 4
);
  logic                   flush;
  logic                   wr_req;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   wr_ack;
  logic                   rd_req;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   rd_valid;
  logic                   full;
  logic                   empty;
  logic [ADDRESS_WIDTH:0] count;

  modport master (
    output flush, wr_req, wr_data, rd_req,
    input  wr_ack, rd_data, rd_valid, full, empty, count
  );

  modport slave (
    input  flush, wr_req, wr_data, rd_req,
    output wr_ack, rd_data, rd_valid, full, empty, count
  );
endinterface

// File: rtl/ring_buffer_ctrl.sv
// Ring buffer controller: arbitrates write/read requests round-robin and
// sequences an external single-port buffer through write and 3-step read cycles.
module ring_buffer_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  ring_buffer_if.slave             bus,
  output logic [ADDRESS_WIDTH-1:0] buf_address,
  output logic [DATA_WIDTH-1:0]    buf_data_in,
  input  logic [DATA_WIDTH-1:0]    buf_data_out,
  output logic                     buf_write,
  output logic                     buf_output_enable,
  output logic                     buf_operational_clock
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    RD_FETCH   = 3'd2,
    RD_CAPTURE = 3'd3,
    RD_DONE    = 3'd4
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR   = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH:0]   DEPTH_COUNT = (ADDRESS_WIDTH + 1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH:0]   COUNT_ONE   = (ADDRESS_WIDTH + 1)'(1'b1);

  state_t                   state_r, state_s;
  logic [ADDRESS_WIDTH-1:0] wr_ptr_r, wr_ptr_s;
  logic [ADDRESS_WIDTH-1:0] rd_ptr_r, rd_ptr_s;
  logic [ADDRESS_WIDTH:0]   count_r, count_s;
  logic                     last_rd_r, last_rd_s;
  logic [DATA_WIDTH-1:0]    rd_data_r, rd_data_s;
  logic                     wr_ack_r, wr_ack_s;
  logic                     rd_valid_r, rd_valid_s;
  logic [ADDRESS_WIDTH-1:0] buf_address_r, buf_address_s;
  logic [DATA_WIDTH-1:0]    buf_data_in_r, buf_data_in_s;
  logic                     buf_write_r, buf_write_s;
  logic                     buf_oe_r, buf_oe_s;
  logic                     buf_clk_r, buf_clk_s;
  logic                     full_s, empty_s, wr_elig_s, rd_elig_s;

  // DEPTH need not be a power of two, so wrap is an explicit compare.
  function automatic logic [ADDRESS_WIDTH-1:0] next_ptr(input logic [ADDRESS_WIDTH-1:0] ptr);
    if (ptr == LAST_ADDR) begin
      return {ADDRESS_WIDTH{1'b0}};
    end else begin
      return ptr + ADDRESS_WIDTH'(1'b1);
    end
  endfunction

  assign full_s    = (count_r == DEPTH_COUNT);
  assign empty_s   = (count_r == {(ADDRESS_WIDTH + 1){1'b0}});
  assign wr_elig_s = bus.wr_req & ~full_s;
  assign rd_elig_s = bus.rd_req & ~empty_s;

  // Next-state, datapath update and output decode of the state being entered.
  always_comb begin
    state_s       = state_r;
    wr_ptr_s      = wr_ptr_r;
    rd_ptr_s      = rd_ptr_r;
    count_s       = count_r;
    last_rd_s     = last_rd_r;
    rd_data_s     = rd_data_r;
    wr_ack_s      = 1'b0;
    rd_valid_s    = 1'b0;
    buf_address_s = {ADDRESS_WIDTH{1'b0}};
    buf_data_in_s = {DATA_WIDTH{1'b0}};
    buf_write_s   = 1'b0;
    buf_oe_s      = 1'b0;
    buf_clk_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (bus.flush) begin
          wr_ptr_s = {ADDRESS_WIDTH{1'b0}};
          rd_ptr_s = {ADDRESS_WIDTH{1'b0}};
          count_s  = {(ADDRESS_WIDTH + 1){1'b0}};
        end else if (wr_elig_s && (!rd_elig_s || last_rd_r)) begin
          state_s   = WRITE;
          last_rd_s = 1'b0;
        end else if (rd_elig_s) begin
          state_s   = RD_FETCH;
          last_rd_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        state_s  = IDLE;
        wr_ptr_s = next_ptr(wr_ptr_r);
        count_s  = count_r + COUNT_ONE;
      end
      RD_FETCH: begin
        state_s = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        state_s   = RD_DONE;
        rd_data_s = buf_data_out;
        rd_ptr_s  = next_ptr(rd_ptr_r);
        count_s   = count_r - COUNT_ONE;
      end
      RD_DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the state about to be entered.
    case (state_s)
      WRITE: begin
        buf_clk_s     = 1'b1;
        buf_write_s   = 1'b1;
        buf_address_s = wr_ptr_r;
        buf_data_in_s = bus.wr_data;
        wr_ack_s      = 1'b1;
      end
      RD_FETCH: begin
        buf_clk_s     = 1'b1;
        buf_address_s = rd_ptr_r;
      end
      RD_CAPTURE: begin
        buf_clk_s     = 1'b1;
        buf_oe_s      = 1'b1;
        buf_address_s = rd_ptr_r;
      end
      RD_DONE: begin
        rd_valid_s = 1'b1;
      end
      IDLE: begin
        buf_clk_s = 1'b0;
      end
      default: begin
        buf_clk_s = 1'b0;
      end
    endcase
  end

  // State, pointers, occupancy and registered outputs; reset aborts any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      wr_ptr_r      <= {ADDRESS_WIDTH{1'b0}};
      rd_ptr_r      <= {ADDRESS_WIDTH{1'b0}};
      count_r       <= {(ADDRESS_WIDTH + 1){1'b0}};
      last_rd_r     <= 1'b1;
      rd_data_r     <= {DATA_WIDTH{1'b0}};
      wr_ack_r      <= 1'b0;
      rd_valid_r    <= 1'b0;
      buf_address_r <= {ADDRESS_WIDTH{1'b0}};
      buf_data_in_r <= {DATA_WIDTH{1'b0}};
      buf_write_r   <= 1'b0;
      buf_oe_r      <= 1'b0;
      buf_clk_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      wr_ptr_r      <= wr_ptr_s;
      rd_ptr_r      <= rd_ptr_s;
      count_r       <= count_s;
      last_rd_r     <= last_rd_s;
      rd_data_r     <= rd_data_s;
      wr_ack_r      <= wr_ack_s;
      rd_valid_r    <= rd_valid_s;
      buf_address_r <= buf_address_s;
      buf_data_in_r <= buf_data_in_s;
      buf_write_r   <= buf_write_s;
      buf_oe_r      <= buf_oe_s;
      buf_clk_r     <= buf_clk_s;
    end
  end

  assign bus.wr_ack            = wr_ack_r;
  assign bus.rd_valid          = rd_valid_r;
  assign bus.rd_data           = rd_data_r;
  assign bus.full              = full_s;
  assign bus.empty             = empty_s;
  assign bus.count             = count_r;
  assign buf_address           = buf_address_r;
  assign buf_data_in           = buf_data_in_r;
  assign buf_write             = buf_write_r;
  assign buf_output_enable     = buf_oe_r;
  assign buf_operational_clock = buf_clk_r;

endmodule

// File: tb/tb_ring_buffer_ctrl.sv
// Self-checking bench for ring_buffer_ctrl: directed scenarios plus random traffic
// against a queue-based model with an attached behavioural buffer memory.
module tb_ring_buffer_ctrl;
  localparam int DW     = 16;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int BUDGET = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] buf_address;
  logic [DW-1:0] buf_data_in;
  logic [DW-1:0] buf_data_out;
  logic          buf_write;
  logic          buf_output_enable;
  logic          buf_operational_clock;
  logic [DW-1:0] mem [DEPTH];

  int checks   = 0;
  int failures = 0;
  int q[$];
  int wptr;
  int rptr;
  bit last_rd;

  ring_buffer_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  ring_buffer_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .bus                   (bus),
    .buf_address           (buf_address),
    .buf_data_in           (buf_data_in),
    .buf_data_out          (buf_data_out),
    .buf_write             (buf_write),
    .buf_output_enable     (buf_output_enable),
    .buf_operational_clock (buf_operational_clock)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (buf_operational_clock && buf_write) mem[buf_address] <= buf_data_in;
  end
  assign buf_data_out = buf_output_enable ? mem[buf_address] : {DW{1'b0}};

  initial begin
    #1000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    q.delete();
    wptr = 0;
    rptr = 0;
  endtask

  // Model arbitration: a tie goes to the side not granted last; returns 1 for write.
  function automatic bit predict_write();
    bit w_el;
    bit r_el;
    w_el = (q.size() < DEPTH);
    r_el = (q.size() > 0);
    if (w_el && r_el) return last_rd;
    return w_el;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
    last_rd = 1'b1;
  endtask

  task automatic do_write(input logic [DW-1:0] d, input int exp_lat);
    int n;
    n = 0;
    bus.wr_data = d;
    bus.wr_req = 1'b1;
    while (bus.wr_ack !== 1'b1 && n < BUDGET) begin
      tick();
      n++;
    end
    chk("wr_ack_seen", 32'(bus.wr_ack), 32'd1);
    if (exp_lat > 0) chk("wr_latency", n, exp_lat);
    chk("wr_buf_ctrl", 32'({buf_operational_clock, buf_write, buf_output_enable}), 32'd6);
    chk("wr_address", 32'(buf_address), wptr);
    chk("wr_data_in", 32'(buf_data_in), 32'(d));
    bus.wr_req = 1'b0;
    q.push_back(int'(d));
    wptr = (wptr + 1) % DEPTH;
    last_rd = 1'b0;
    tick();
    chk("wr_ack_width", 32'(bus.wr_ack), 32'd0);
    chk("count_after_wr", 32'(bus.count), q.size());
  endtask

  task automatic do_read(input int exp_lat);
    int n;
    int expv;
    logic [31:0] cap_addr;
    n = 0;
    cap_addr = 32'hFFFF_FFFF;
    bus.rd_req = 1'b1;
    while (bus.rd_valid !== 1'b1 && n < BUDGET) begin
      tick();
      n++;
      if (buf_output_enable === 1'b1) cap_addr = 32'(buf_address);
    end
    expv = (q.size() > 0) ? q.pop_front() : -1;
    chk("rd_valid_seen", 32'(bus.rd_valid), 32'd1);
    if (exp_lat > 0) chk("rd_latency", n, exp_lat);
    chk("rd_data", 32'(bus.rd_data), 32'(expv[DW-1:0]));
    chk("rd_address", cap_addr, rptr);
    bus.rd_req = 1'b0;
    rptr = (rptr + 1) % DEPTH;
    last_rd = 1'b1;
    tick();
    chk("rd_valid_width", 32'(bus.rd_valid), 32'd0);
    chk("rd_data_hold", 32'(bus.rd_data), 32'(expv[DW-1:0]));
    chk("count_after_rd", 32'(bus.count), q.size());
  endtask

  task automatic flush_idle();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    model_clear();
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_empty", 32'(bus.empty), 32'd1);
  endtask

  // Both requesters hold continuously, re-raising the cycle after each ack.
  task automatic arb(input int n_grants);
    int grants;
    int cyc;
    int expv;
    bit exp_w;
    bit re_w;
    bit re_r;
    logic [DW-1:0] wd;
    grants = 0;
    cyc = 0;
    re_w = 1'b0;
    re_r = 1'b0;
    wd = 16'($urandom);
    bus.wr_data = wd;
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    exp_w = predict_write();
    while (grants < n_grants && cyc < BUDGET * n_grants) begin
      tick();
      cyc++;
      if (re_w) begin
        wd = 16'($urandom);
        bus.wr_data = wd;
        bus.wr_req = 1'b1;
        re_w = 1'b0;
      end
      if (re_r) begin
        bus.rd_req = 1'b1;
        re_r = 1'b0;
      end
      if (bus.wr_ack === 1'b1 || bus.rd_valid === 1'b1) begin
        chk("arb_order", 32'({bus.wr_ack, bus.rd_valid}), exp_w ? 32'd2 : 32'd1);
        if (bus.wr_ack === 1'b1) begin
          chk("arb_wr_address", 32'(buf_address), wptr);
          q.push_back(int'(wd));
          wptr = (wptr + 1) % DEPTH;
          last_rd = 1'b0;
          bus.wr_req = 1'b0;
          re_w = 1'b1;
        end else begin
          expv = (q.size() > 0) ? q.pop_front() : -1;
          chk("arb_rd_data", 32'(bus.rd_data), 32'(expv[DW-1:0]));
          rptr = (rptr + 1) % DEPTH;
          last_rd = 1'b1;
          bus.rd_req = 1'b0;
          re_r = 1'b1;
        end
        grants++;
        exp_w = predict_write();
      end
    end
    chk("arb_grants", grants, n_grants);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    tick();
    chk("arb_count", 32'(bus.count), q.size());
  endtask

  initial begin
    int acks;
    int bad;
    int n;
    int expv;
    int r;

    rst = 1'b1;
    bus.flush = 1'b0;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    bus.wr_data = {DW{1'b0}};
    tick();
    tick();
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_flags", 32'({bus.empty, bus.full}), 32'd2);
    chk("rst_acks", 32'({bus.wr_ack, bus.rd_valid}), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_buf_ctrl", 32'({buf_operational_clock, buf_write, buf_output_enable}), 32'd0);
    chk("rst_buf_bus", 32'({buf_address, buf_data_in}), 32'd0);
    rst = 1'b0;
    model_clear();
    last_rd = 1'b1;

    // Basic write then read.
    do_write(16'h1234, 1);
    do_read(3);

    // Read while empty stalls, then a write unblocks it.
    bus.rd_req = 1'b1;
    bad = 0;
    repeat (10) begin
      tick();
      if (bus.rd_valid !== 1'b0 || buf_operational_clock !== 1'b0) bad++;
    end
    chk("empty_stall", bad, 0);
    do_write(16'hBEEF, 1);
    do_read(3);

    // Fill, overfill stall, wrap.
    apply_reset();
    for (int i = 0; i < DEPTH; i++) do_write(16'(i), 1);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.count), 32'd16);
    bus.wr_data = 16'd16;
    bus.wr_req = 1'b1;
    acks = 0;
    repeat (5) begin
      tick();
      if (bus.wr_ack === 1'b1) acks++;
    end
    chk("full_stall", acks, 0);
    do_read(3);
    do_write(16'd16, 1);
    for (int i = 0; i < DEPTH; i++) do_read(3);
    chk("drain_empty", 32'(bus.empty), 32'd1);

    // Arbitration from reset, then from a random occupancy.
    apply_reset();
    arb(8);
    n = $urandom_range(2, 14);
    for (int i = 0; i < n; i++) do_write(16'($urandom), 1);
    arb(10);

    // Flush in IDLE with five entries, then flush during a read fetch.
    flush_idle();
    for (int i = 0; i < 5; i++) do_write(16'(16'h0100 + i), 1);
    chk("five_stored", 32'(bus.count), 32'd5);
    flush_idle();
    do_write(16'hA5A5, 1);
    do_write(16'h5AA5, 1);
    bus.rd_req = 1'b1;
    tick();
    chk("fetch_ctrl", 32'({buf_operational_clock, buf_write, buf_output_enable}), 32'd4);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("capture_ctrl", 32'({buf_operational_clock, buf_write, buf_output_enable}), 32'd5);
    n = 0;
    while (bus.rd_valid !== 1'b1 && n < BUDGET) begin
      tick();
      n++;
    end
    chk("flush_rd_valid", 32'(bus.rd_valid), 32'd1);
    expv = q.pop_front();
    chk("flush_rd_data", 32'(bus.rd_data), 32'(expv[DW-1:0]));
    bus.rd_req = 1'b0;
    rptr = (rptr + 1) % DEPTH;
    last_rd = 1'b1;
    tick();
    chk("flush_ignored_count", 32'(bus.count), q.size());
    do_read(3);

    // Reset during RD_CAPTURE aborts the read.
    do_write(16'h5A5A, 1);
    bus.rd_req = 1'b1;
    tick();
    tick();
    chk("pre_rst_capture", 32'(buf_output_enable), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_count", 32'(bus.count), 32'd0);
    chk("midrst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("midrst_outputs", 32'({bus.rd_valid, buf_operational_clock, buf_output_enable}), 32'd0);
    bus.rd_req = 1'b0;
    tick();
    rst = 1'b0;
    model_clear();
    last_rd = 1'b1;
    bad = 0;
    repeat (4) begin
      tick();
      if (bus.rd_valid !== 1'b0) bad++;
    end
    chk("midrst_no_valid", bad, 0);
    do_write(16'h0F0F, 1);

    // Random single-requester traffic with occasional flushes.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 11);
      if (r == 11) begin
        flush_idle();
      end else if ((r < 6 && q.size() < DEPTH) || q.size() == 0) begin
        do_write(16'($urandom), 1);
      end else begin
        do_read(3);
      end
    end
    chk("final_count", 32'(bus.count), q.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
